// File: rtl/divider4_pkg.sv
// Shared definitions for the divider datapath and the surrounding ALU opcode space.
// No latency of its own; no flow control.
// Holds the FSM state encodings, operand width and ALU opcode values.
package divider4_pkg;

    localparam int DIV_W = 4;
    localparam int SUB_W = DIV_W + 1;

    localparam logic [1:0] ITER_LOAD = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } div_state_t;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_DIV = 3'd5
    } alu_op_t;

endpackage

// File: rtl/divsub5.sv
// 5-bit trial subtractor a - b as a + ~b + 1 over a ripple of full adders.
// Combinational, zero latency.
// No flow control; borrow is the inverted final carry.
module divsub5
    import divider4_pkg::*;
(
    input  logic [SUB_W-1:0] a,
    input  logic [SUB_W-1:0] b,
    output logic [SUB_W-1:0] diff,
    output logic             borrow
);

    logic [SUB_W:0] carry;

    assign carry[0] = 1'b1;

    for (genvar i = 0; i < SUB_W; i++) begin : g_fa
        fulladder u_fa (
            .a  (a[i]),
            .b  (~b[i]),
            .ci (carry[i]),
            .s  (diff[i]),
            .co (carry[i+1])
        );
    end

    assign borrow = ~carry[SUB_W];

endmodule

// File: rtl/fulladder.sv
// One-bit full adder cell.
// Combinational, zero latency.
// No flow control.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/divider4.sv
// 4-bit unsigned restoring divider, one quotient bit per cycle.
// Latency: done 5 cycles after an accepted start (1 cycle when B is 0).
// Backpressure: start is accepted only in IDLE; pulses while busy are dropped, never queued.
module divider4
    import divider4_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DIV_W-1:0] A,
    input  logic [DIV_W-1:0] B,
    output logic [DIV_W-1:0] Q,
    output logic [DIV_W-1:0] R,
    output logic             busy,
    output logic             done,
    output logic             divzero
);

    div_state_t state_q, state_d;

    logic [1:0]       cnt_q, cnt_d;
    logic [DIV_W-1:0] rem_q, rem_d;
    logic [DIV_W-1:0] dvd_q, dvd_d;
    logic [DIV_W-1:0] dvs_q, dvs_d;
    logic [DIV_W-1:0] quo_q, quo_d;
    logic [DIV_W-1:0] rmd_q, rmd_d;
    logic             dz_q, dz_d;

    logic             accept;
    logic [SUB_W-1:0] trial_a;
    logic [SUB_W-1:0] trial_diff;
    logic             trial_borrow;
    logic [DIV_W-1:0] step_rem;
    logic [DIV_W-1:0] step_dvd;

    assign accept = (state_q == S_IDLE) && start;

    // Remainder shifted left with the next dividend bit appended.
    assign trial_a = {rem_q, dvd_q[DIV_W-1]};

    divsub5 u_sub (
        .a      (trial_a),
        .b      ({1'b0, dvs_q}),
        .diff   (trial_diff),
        .borrow (trial_borrow)
    );

    // A successful trial always leaves a difference below the divisor.
    always_comb begin
        if (state_q == S_CALC && !trial_borrow) begin
            assert (trial_diff[SUB_W-1] == 1'b0);
        end
    end

    assign step_rem = trial_borrow ? trial_a[DIV_W-1:0] : trial_diff[DIV_W-1:0];
    assign step_dvd = {dvd_q[DIV_W-2:0], ~trial_borrow};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (B == '0) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (cnt_q == 2'd0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == S_CALC) || (state_q == S_DONE);
        done = (state_q == S_DONE);
    end

    always_comb begin
        rem_d = rem_q;
        dvd_d = dvd_q;
        dvs_d = dvs_q;
        cnt_d = cnt_q;
        quo_d = quo_q;
        rmd_d = rmd_q;
        dz_d  = dz_q;
        if (accept) begin
            rem_d = '0;
            dvd_d = A;
            dvs_d = B;
            cnt_d = ITER_LOAD;
            dz_d  = (B == '0);
            if (B == '0) begin
                quo_d = '1;
                rmd_d = A;
            end
        end else if (state_q == S_CALC) begin
            rem_d = step_rem;
            dvd_d = step_dvd;
            if (cnt_q != 2'd0) begin
                cnt_d = cnt_q - 2'd1;
            end else begin
                // Last step: publish the result so it is stable throughout DONE.
                quo_d = step_dvd;
                rmd_d = step_rem;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            dvd_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
            quo_q <= '0;
            rmd_q <= '0;
            dz_q  <= 1'b0;
        end else begin
            rem_q <= rem_d;
            dvd_q <= dvd_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
            quo_q <= quo_d;
            rmd_q <= rmd_d;
            dz_q  <= dz_d;
        end
    end

    assign Q       = quo_q;
    assign R       = rmd_q;
    assign divzero = dz_q;

endmodule
